// File: rtl/apb_requester.sv
// Single-outstanding APB4 requester: turns a command/response handshake into
// APB SETUP/ACCESS transfers, with an optional wait-state timeout.
module apb_requester #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0]     paddr_q;
    logic [DATA_W-1:0]     pwdata_q;
    logic [DATA_W/8-1:0]   pstrb_q;
    logic                  rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [DATA_W-1:0]     rsp_rdata_q;

    assign cmd_ready = (state_q == IDLE) & ~preset;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pwdata_q  <= cmd_wdata;
                        pstrb_q   <= cmd_write ? cmd_strb : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= (!pwrite_q && !pslverr) ? prdata : '0;
                        state_q       <= IDLE;
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                        state_q       <= IDLE;
                    end else if (cnt_q != '1) begin
                        // Saturating so a disabled timeout never wraps.
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester: write, waited read, slave error, timeout,
// mid-transfer reset and back-to-back queued reads.
module tb_apb_requester;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;

    int checks = 0;
    int errors = 0;

    apb_requester #(.ADDR_W(12), .DATA_W(32), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int   acc_cyc [4];
    int   nacc, nrsp;
    logic acc;

    initial begin
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        tick(); tick();
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", paddr, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        preset = 1'b0; #1;
        check("idle_cmd_ready", cmd_ready, 1);

        // Write, zero wait states
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h010;
        cmd_wdata = 32'hA5A5_0001; cmd_strb = 4'hF; pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("wr_setup_sel_en", {psel, penable}, 2'b10);
        check("wr_paddr", paddr, 12'h010);
        check("wr_pwdata", pwdata, 32'hA5A5_0001);
        check("wr_pstrb", pstrb, 4'hF);
        check("wr_pwrite", pwrite, 1);
        check("wr_setup_ready", cmd_ready, 0);
        tick();
        check("wr_access_sel_en", {psel, penable}, 2'b11);
        check("wr_access_no_rsp", rsp_valid, 0);
        tick();
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_end_sel_en", {psel, penable}, 2'b00);
        check("wr_paddr_hold", paddr, 12'h010);
        tick();
        check("wr_rsp_pulse", rsp_valid, 0);

        // Read with 3 wait states; junk on prdata/pslverr while waiting
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h004;
        cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hF; pready = 1'b0;
        prdata = 32'h1111_1111; pslverr = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("rd_pstrb_zero", pstrb, 0);
        check("rd_pwrite", pwrite, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("rd_wait_penable", penable, 1);
            check("rd_wait_paddr", paddr, 12'h004);
            check("rd_wait_no_rsp", rsp_valid, 0);
            if (i == 3) begin
                pready = 1'b1; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
            end
            tick();
        end
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        check("rd_rsp_err", rsp_err, 0);
        check("rd_penable_drop", penable, 0);
        prdata = '0;

        // Write with slave error, next command on the response cycle
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020;
        cmd_wdata = 32'h1234_5678; cmd_strb = 4'h3; pready = 1'b1; pslverr = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("err_pstrb", pstrb, 4'h3);
        tick(); tick();
        check("err_rsp_valid", rsp_valid, 1);
        check("err_rsp_err", rsp_err, 1);
        check("err_rsp_timeout", rsp_timeout, 0);
        check("err_rsp_rdata", rsp_rdata, 0);
        check("err_cmd_ready", cmd_ready, 1);

        // Timeout read, accepted on that response cycle
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h030;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hCAFE_F00D;
        tick();
        cmd_valid = 1'b0;
        check("to_accept_psel", psel, 1);
        check("to_rsp_pulse", rsp_valid, 0);
        check("to_err_held", rsp_err, 1);
        tick();
        for (int i = 0; i < 16; i++) begin
            check("to_wait_sel_en", {psel, penable}, 2'b11);
            check("to_wait_no_rsp", rsp_valid, 0);
            tick();
        end
        check("to_end_sel_en", {psel, penable}, 2'b00);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);

        // Normal read after the timeout
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h044;
        pready = 1'b1; prdata = 32'h0BAD_F00D;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("post_to_rsp_valid", rsp_valid, 1);
        check("post_to_rdata", rsp_rdata, 32'h0BAD_F00D);
        check("post_to_err", rsp_err, 0);
        check("post_to_timeout", rsp_timeout, 0);

        // Reset during the second wait cycle of a read
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h008; pready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick(); tick();
        check("rst_mid_penable_before", penable, 1);
        preset = 1'b1; pready = 1'b1; #1;
        check("rst_mid_cmd_ready", cmd_ready, 0);
        tick();
        check("rst_mid_sel_en", {psel, penable}, 2'b00);
        check("rst_mid_no_rsp", rsp_valid, 0);
        preset = 1'b0; #1;
        check("rst_mid_ready_after", cmd_ready, 1);
        pready = 1'b1;
        tick();
        check("rst_mid_still_no_rsp", rsp_valid, 0);

        // Four queued reads held on cmd_valid
        prdata = 32'h0000_0077; pslverr = 1'b0; pready = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_strb = 4'hF; cmd_addr = 12'h100;
        nacc = 0; nrsp = 0;
        for (int c = 0; c < 40 && nrsp < 4; c++) begin
            acc = cmd_valid & cmd_ready;
            tick();
            if (rsp_valid) begin
                nrsp++;
                check("q_rsp_rdata", rsp_rdata, 32'h0000_0077);
            end
            if (acc) begin
                acc_cyc[nacc] = c;
                nacc++;
                check("q_pstrb_zero", pstrb, 0);
                check("q_paddr", paddr, 32'(12'h100 + 12'(4 * (nacc - 1))));
                if (nacc == 4) cmd_valid = 1'b0;
                else cmd_addr = 12'h100 + 12'(4 * nacc);
            end
        end
        check("q_accepts", nacc, 4);
        check("q_responses", nrsp, 4);
        for (int k = 1; k < 4; k++)
            if (k < nacc) check("q_spacing", acc_cyc[k] - acc_cyc[k-1], 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- Single-outstanding APB4 requester (initiator).
- Converts a simple command/response interface into APB SETUP/ACCESS transfers on the UART APB port.
- Drives the same bus signals the APB protocol checker monitors; it is the active counterpart used by the environment's standalone bring-up bench and by the on-chip config path.
- Has a wait-state timeout so a hung completer cannot stall the command source.

Parameters:
ADDR_W, 12, APB address width (paddr, cmd_addr)
DATA_W, 32, APB data width; multiple of 8
TIMEOUT, 16, max ACCESS cycles with pready=0 before abort; 0 disables timeout

Ports:
pclk  in  1  clock; single clock domain
preset  in  1  reset, synchronous, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready at pclk edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data
rsp_err  out  1  pslverr or timeout
rsp_timeout  out  1  transfer aborted by timeout
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_W  APB address
pwdata  out  DATA_W  APB write data
pstrb  out  DATA_W/8  APB strobes
prdata  in  DATA_W  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- Clock pclk; reset preset is synchronous and active-high. All state and outputs are registered except cmd_ready.
- Reset values: psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, and the wait counter are all 0; state=IDLE.
- cmd_ready = (state==IDLE) & ~preset.
- FSM IDLE -> SETUP -> ACCESS -> IDLE:
  - IDLE: on accept, latch cmd_* into pwrite/paddr/pwdata/pstrb; psel<=1, penable<=0; go to SETUP. pstrb<=0 when cmd_write=0 (APB4 read rule).
  - SETUP: one cycle; penable<=1; wait counter<=0; go to ACCESS.
  - ACCESS, pready=1: psel<=0, penable<=0, rsp_valid<=1, rsp_err<=pslverr, rsp_timeout<=0. rsp_rdata<=prdata only if read and pslverr=0, else 0. Go to IDLE.
  - ACCESS, pready=0, TIMEOUT!=0, counter==TIMEOUT-1: abort. psel<=0, penable<=0, rsp_valid<=1, rsp_err<=1, rsp_timeout<=1, rsp_rdata<=0. Go to IDLE.
  - ACCESS, pready=0 otherwise: counter increments (width $clog2(TIMEOUT+1), saturates); stay in ACCESS.
- paddr, pwrite, pwdata, pstrb hold stable from SETUP through the end of ACCESS. They retain their last values in IDLE; only psel/penable drop.
- prdata and pslverr are sampled only in ACCESS with pready=1; ignored at all other times.
- rsp_valid is high exactly one cycle; rsp_rdata/rsp_err/rsp_timeout hold until the next response.
- Latency with zero wait states: accept at edge N; SETUP in cycle N+1; ACCESS in N+2; rsp_valid in N+3; next accept at edge N+3. Minimum 3 cycles per transfer; each wait state adds 1.
- Reset mid-transfer (any state): the next edge forces reset values and IDLE; no rsp_valid is produced for the aborted transfer.
- Exactly one transfer is outstanding; the command source must hold cmd_* stable while cmd_valid=1 and cmd_ready=0.

Test Plan:
- Write, addr 0x010, data 0xA5A5_0001, strb 0xF, pready=1 -> SETUP then one ACCESS cycle with paddr=0x010, pwdata=0xA5A5_0001, pstrb=0xF; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr 0x004, 3 wait states, prdata=0xDEAD_BEEF on the ready cycle -> penable high 4 cycles with paddr stable, pstrb=0; rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write with pslverr=1 on the ready cycle -> rsp_err=1, rsp_timeout=0; next command accepted on the response cycle.
- TIMEOUT=16, pready stuck 0 -> after 16 ACCESS cycles psel/penable drop; rsp_err=1, rsp_timeout=1, rsp_rdata=0; a following read completes normally.
- preset=1 during the 2nd wait cycle of a read -> next edge psel=0, penable=0, no rsp_valid; cmd_ready=1 on the first cycle after preset=0.
- cmd_valid held high with 4 queued reads, pready=1 -> accepts spaced exactly 3 cycles apart, 4 rsp_valid pulses, pstrb=0 on every transfer.
